// File: rtl/axi_wr_sched.sv
// rtl/axi_wr_sched.sv - Round-robin AW scheduler with in-order W steering and B routing by ID
module axi_wr_sched #(
  parameter int NumReq = 3,
  parameter int IdWidth = 4,
  parameter int DataWidth = 64,
  parameter int FifoDepth = 4,
  parameter int MaxOutstanding = 4,
  parameter logic [NumReq-1:0][IdWidth-1:0] ReqId = {4'b0111, 4'b1000, 4'b0000}
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_aw_valid_i,
  output logic [NumReq-1:0]           req_aw_ready_o,
  input  logic [NumReq-1:0]           req_w_valid_i,
  input  logic [NumReq-1:0]           req_w_last_i,
  input  logic [NumReq*DataWidth-1:0] req_w_data_i,
  output logic [NumReq-1:0]           req_w_ready_o,
  output logic [NumReq-1:0]           req_b_valid_o,
  input  logic [NumReq-1:0]           req_b_ready_i,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [IdWidth-1:0]          aw_id_o,
  output logic [$clog2(NumReq)-1:0]   aw_sel_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [DataWidth-1:0]        w_data_o,
  output logic                        w_last_o,
  input  logic                        b_valid_i,
  input  logic [IdWidth-1:0]          b_id_i,
  output logic                        b_ready_o,
  output logic                        busy_o,
  output logic                        b_err_o
);
  localparam int SelW = $clog2(NumReq);
  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   lock_sel_q;
  logic [SelW-1:0]   rr_ptr_q;
  logic [SelW-1:0]   fifo_q [FifoDepth];
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   outst_q [NumReq];

  logic              fifo_empty, fifo_full, q_room;
  logic [SelW-1:0]   head;
  logic              head_pop, ft_pop, push;
  logic              b_hit, b_hs;
  logic [SelW-1:0]   b_idx;
  logic [NumReq-1:0] eligible, inc_vec, dec_vec;
  logic              gnt_valid, aw_hs;
  logic [SelW-1:0]   gnt_idx, cand;
  logic              sel_ok;
  logic [SelW-1:0]   sel;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign head       = fifo_q[rd_ptr_q[PtrW-1:0]];
  // Room is judged from the head-pop alone so the fall-through path cannot loop back into eligibility.
  assign head_pop   = !fifo_empty && req_w_valid_i[head] && w_ready_i && req_w_last_i[head];
  assign q_room     = !fifo_full || head_pop;

  always_comb begin
    b_hit = 1'b0;
    b_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (b_id_i == ReqId[i]) begin
        b_hit = 1'b1;
        b_idx = SelW'(i);
      end
    end
  end

  assign b_ready_o = b_hit ? req_b_ready_i[b_idx] : 1'b1;
  assign b_hs      = b_valid_i && b_hit && req_b_ready_i[b_idx];
  assign b_err_o   = b_valid_i && !b_hit;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      req_b_valid_o[i] = b_valid_i && b_hit && (b_idx == SelW'(i));
      dec_vec[i]       = b_hs && (b_idx == SelW'(i));
      eligible[i]      = req_aw_valid_i[i] && q_room && ((outst_q[i] < MaxCnt) || dec_vec[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (state_q == LOCKED) begin
      gnt_valid = 1'b1;
      gnt_idx   = lock_sel_q;
    end else begin
      for (int off = 0; off < NumReq; off++) begin
        cand = SelW'((int'(rr_ptr_q) + off) % NumReq);
        if (!gnt_valid && eligible[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (gnt_valid && !aw_ready_i) state_d = LOCKED;
    else if (gnt_valid)           state_d = IDLE;
  end

  assign aw_hs      = gnt_valid && aw_ready_i;
  assign aw_valid_o = gnt_valid;
  assign aw_sel_o   = gnt_idx;
  assign aw_id_o    = ReqId[gnt_idx];

  assign sel_ok = !fifo_empty || aw_hs;
  assign sel    = fifo_empty ? gnt_idx : head;

  always_comb begin
    w_data_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_aw_ready_o[i] = aw_hs && (gnt_idx == SelW'(i));
      inc_vec[i]        = req_aw_ready_o[i];
      req_w_ready_o[i]  = sel_ok && w_ready_i && (sel == SelW'(i));
      if (sel == SelW'(i)) w_data_o = req_w_data_i[i*DataWidth +: DataWidth];
    end
  end

  assign w_valid_o = sel_ok && req_w_valid_i[sel];
  assign w_last_o  = req_w_last_i[sel];
  // A single-beat burst that completes alongside its own AW never enters the queue.
  assign ft_pop    = fifo_empty && aw_hs && w_valid_o && w_ready_i && w_last_o;
  assign push      = aw_hs && !ft_pop;

  always_comb begin
    busy_o = !fifo_empty;
    for (int i = 0; i < NumReq; i++) begin
      if (outst_q[i] != '0) busy_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < NumReq; i++) outst_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_valid) lock_sel_q <= gnt_idx;
      if (aw_hs) rr_ptr_q <= (gnt_idx == SelW'(NumReq - 1)) ? '0 : gnt_idx + SelW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
      if (head_pop) rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
      for (int i = 0; i < NumReq; i++) begin
        if (inc_vec[i] && !dec_vec[i] && (outst_q[i] != MaxCnt))
          outst_q[i] <= outst_q[i] + CntW'(1);
        else if (dec_vec[i] && !inc_vec[i] && (outst_q[i] != '0))
          outst_q[i] <= outst_q[i] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q[PtrW-1:0]] <= gnt_idx;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && b_hs) assert (outst_q[b_idx] != '0);
  end

endmodule

// File: tb/tb_axi_wr_sched.sv
// tb/tb_axi_wr_sched.sv - Directed self-checking bench for axi_wr_sched
module tb_axi_wr_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_aw_valid, req_aw_ready;
  logic [2:0]   req_w_valid, req_w_last, req_w_ready;
  logic [191:0] req_w_data;
  logic [2:0]   req_b_valid, req_b_ready;
  logic         aw_valid, aw_ready;
  logic [3:0]   aw_id;
  logic [1:0]   aw_sel;
  logic         w_valid, w_ready, w_last;
  logic [63:0]  w_data;
  logic         b_valid, b_ready, busy, b_err;
  logic [3:0]   b_id;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_wr_sched dut (
    .clk_i(clk), .rst_i(rst),
    .req_aw_valid_i(req_aw_valid), .req_aw_ready_o(req_aw_ready),
    .req_w_valid_i(req_w_valid), .req_w_last_i(req_w_last),
    .req_w_data_i(req_w_data), .req_w_ready_o(req_w_ready),
    .req_b_valid_o(req_b_valid), .req_b_ready_i(req_b_ready),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_id_o(aw_id), .aw_sel_o(aw_sel),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_last_o(w_last),
    .b_valid_i(b_valid), .b_id_i(b_id), .b_ready_o(b_ready),
    .busy_o(busy), .b_err_o(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [3:0] id, input logic [2:0] exp_vld);
    b_valid = 1'b1; b_id = id; req_b_ready = 3'b111;
    #1;
    chk("b_route", req_b_valid, exp_vld);
    chk("b_ready", b_ready, 1);
    cyc();
    b_valid = 1'b0; b_id = 4'b0000; req_b_ready = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    req_aw_valid = '0; req_w_valid = '0; req_w_last = '0; req_w_data = '0;
    req_b_ready = '0; aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_id = '0;
    cyc(); cyc();
    chk("rst_aw_valid", aw_valid, 0);
    chk("rst_aw_sel", aw_sel, 0);
    chk("rst_aw_id", aw_id, 4'b0000);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_b_err", b_err, 0);
    rst = 1'b0;
    cyc();

    // Round-robin across all three requesters, then full-queue behaviour
    aw_ready = 1'b1; req_aw_valid = 3'b111;
    #1;
    chk("rr0_sel", aw_sel, 0); chk("rr0_id", aw_id, 4'b0000); chk("rr0_ack", req_aw_ready, 3'b001);
    cyc(); #1;
    chk("rr1_sel", aw_sel, 1); chk("rr1_id", aw_id, 4'b1000); chk("rr1_ack", req_aw_ready, 3'b010);
    cyc(); #1;
    chk("rr2_sel", aw_sel, 2); chk("rr2_id", aw_id, 4'b0111);
    cyc(); #1;
    chk("rr3_sel", aw_sel, 0); chk("rr3_id", aw_id, 4'b0000);
    cyc(); #1;
    chk("full_mask", aw_valid, 0);
    req_w_valid = 3'b001; req_w_last = 3'b001; w_ready = 1'b1;
    #1;
    chk("full_pop_wvalid", w_valid, 1);
    chk("full_push_valid", aw_valid, 1);
    chk("full_push_sel", aw_sel, 1);
    cyc();
    req_aw_valid = 3'b000; req_w_valid = 3'b111; req_w_last = 3'b111;
    #1; chk("drain0", req_w_ready, 3'b010); cyc();
    #1; chk("drain1", req_w_ready, 3'b100); cyc();
    #1; chk("drain2", req_w_ready, 3'b001); cyc();
    #1; chk("drain3", req_w_ready, 3'b010); cyc();
    #1; chk("drain_empty", w_valid, 0); chk("drain_busy", busy, 1);
    req_w_valid = '0; req_w_last = '0; w_ready = 1'b0;
    send_b(4'b0000, 3'b001); send_b(4'b0000, 3'b001);
    send_b(4'b1000, 3'b010); send_b(4'b1000, 3'b010);
    #1; chk("rr_busy_before", busy, 1);
    send_b(4'b0111, 3'b100);
    #1; chk("rr_busy_after", busy, 0);

    // Lock: req1 held while req0 raises valid
    aw_ready = 1'b0; req_aw_valid = 3'b010;
    #1; chk("lock_sel0", aw_sel, 1); chk("lock_valid", aw_valid, 1);
    cyc();
    req_aw_valid = 3'b011;
    #1; chk("lock_sel1", aw_sel, 1); chk("lock_noack", req_aw_ready, 3'b000);
    cyc(); #1; chk("lock_sel2", aw_sel, 1);
    cyc();
    aw_ready = 1'b1;
    #1; chk("lock_hs_sel", aw_sel, 1); chk("lock_hs_ack", req_aw_ready, 3'b010);
    cyc(); #1;
    chk("lock_next", aw_sel, 0);
    cyc();
    req_aw_valid = '0; req_w_valid = 3'b011; req_w_last = 3'b011; w_ready = 1'b1;
    #1; chk("lock_w0", req_w_ready, 3'b010); cyc();
    #1; chk("lock_w1", req_w_ready, 3'b001); cyc();
    req_w_valid = '0; req_w_last = '0;
    send_b(4'b1000, 3'b010); send_b(4'b0000, 3'b001);

    // W ordering: AW req2 then req1; req1 offers W first and must wait
    req_aw_valid = 3'b100; req_w_valid = 3'b010; req_w_last = 3'b000;
    #1; chk("ord_aw2", aw_sel, 2); chk("ord_stall0_v", w_valid, 0); chk("ord_stall0_r", req_w_ready, 3'b100);
    cyc();
    req_aw_valid = 3'b010;
    #1; chk("ord_aw1", aw_sel, 1); chk("ord_stall1_v", w_valid, 0); chk("ord_stall1_r", req_w_ready, 3'b100);
    cyc();
    req_aw_valid = '0; req_w_valid = 3'b110;
    req_w_data[128 +: 64] = 64'hA1; req_w_data[64 +: 64] = 64'hB1;
    #1; chk("ord_a1_data", w_data, 64'hA1); chk("ord_a1_last", w_last, 0); chk("ord_a1_rdy", req_w_ready, 3'b100);
    cyc();
    req_w_data[128 +: 64] = 64'hA2; req_w_last = 3'b100;
    #1; chk("ord_a2_data", w_data, 64'hA2); chk("ord_a2_last", w_last, 1);
    cyc();
    req_w_valid = 3'b010; req_w_last = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      req_w_data[64 +: 64] = 64'hB0 + 64'(k);
      if (k == 4) req_w_last = 3'b010;
      #1; chk("ord_b_data", w_data, 64'hB0 + 64'(k)); chk("ord_b_rdy", req_w_ready, 3'b010);
      cyc();
    end
    #1; chk("ord_done", w_valid, 0);
    req_w_valid = '0; req_w_last = '0;
    send_b(4'b0111, 3'b100); send_b(4'b1000, 3'b010);

    // Fall-through single beat with its AW
    req_aw_valid = 3'b010; req_w_valid = 3'b010; req_w_last = 3'b010;
    req_w_data[64 +: 64] = 64'hB9;
    #1; chk("ft_sel", aw_sel, 1); chk("ft_wvalid", w_valid, 1); chk("ft_last", w_last, 1);
    chk("ft_data", w_data, 64'hB9); chk("ft_rdy", req_w_ready, 3'b010);
    cyc();
    req_aw_valid = '0;
    #1; chk("ft_q_empty", w_valid, 0); chk("ft_busy", busy, 1);
    req_w_valid = '0; req_w_last = '0;
    send_b(4'b1000, 3'b010);

    // Throttle: req0 reaches MaxOutstanding; B frees a slot in the same cycle
    req_aw_valid = 3'b001; req_w_valid = 3'b001; req_w_last = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1; chk("thr_aw_valid", aw_valid, 1); chk("thr_aw_sel", aw_sel, 0);
      cyc();
    end
    #1; chk("thr_masked", aw_valid, 0); chk("thr_busy", busy, 1);
    b_valid = 1'b1; b_id = 4'b0000; req_b_ready = 3'b001;
    #1; chk("thr_free_valid", aw_valid, 1); chk("thr_free_ack", req_aw_ready, 3'b001);
    chk("thr_b_route", req_b_valid, 3'b001);
    cyc();
    b_valid = 1'b0; req_b_ready = '0; req_aw_valid = '0; req_w_valid = '0; req_w_last = '0;
    send_b(4'b0000, 3'b001); send_b(4'b0000, 3'b001); send_b(4'b0000, 3'b001);
    #1; chk("thr_busy_before", busy, 1);
    send_b(4'b0000, 3'b001);
    #1; chk("thr_busy_after", busy, 0);

    // Unknown B ID is acknowledged and flagged for one cycle
    b_valid = 1'b1; b_id = 4'b0011; req_b_ready = 3'b000;
    #1; chk("unk_ready", b_ready, 1); chk("unk_err", b_err, 1); chk("unk_route", req_b_valid, 3'b000);
    cyc();
    b_valid = 1'b0; b_id = 4'b0000;
    #1; chk("unk_err_end", b_err, 0); chk("unk_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
